// File: rtl/stack_drain_reader.sv
// stack_drain_reader: consumer side of the LED stack interface.
// Pops a LIFO either one entry at a time (single) or as a paced full drain
// (start), latching each popped value onto the LEDs for HOLD_CYCLES cycles.
// Optional build macro STACK_DRAIN_BLANK_EN: adds a BLANK phase of
// HOLD_CYCLES cycles (LEDs dark) after every HOLD so repeated values stay
// visibly separated.
//
// Handshake: the stack presents s_rd_data whenever s_empty=0; s_pop is a
// one-cycle strobe decoded from the POP state, and the value on s_rd_data
// during that cycle is the one consumed on the closing edge.
module stack_drain_reader #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             single,
    input  logic             abort,
    input  logic             s_empty,
    input  logic [WIDTH-1:0] s_rd_data,
    output logic             s_pop,
    output logic [WIDTH-1:0] led,
    output logic             led_valid,
    output logic             busy,
    output logic             done,
    output logic             underflow,
    output logic [7:0]       pop_count,
    output logic [2:0]       dbg_state_o
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHECK = 3'd1;
    localparam logic [2:0] POP   = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
`ifdef STACK_DRAIN_BLANK_EN
    localparam logic [2:0] BLANK = 3'd5;
`endif

    logic [2:0]       state_q, state_d;
    logic             single_q, single_d;   // current pop came from a single request
    logic [CW-1:0]    hold_q, hold_d;
    logic [WIDTH-1:0] led_q;
    logic             led_valid_q;
    logic [7:0]       pop_count_q;
    logic             underflow_q;

    // Next-state and hold-counter logic for the drain FSM.
    always_comb begin
        state_d  = state_q;
        single_d = single_q;
        hold_d   = hold_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CHECK;
                    single_d = 1'b0;
                end else if (single && !s_empty) begin
                    state_d  = POP;
                    single_d = 1'b1;
                end
            end
            CHECK: begin
                if (abort)        state_d = IDLE;
                else if (s_empty) state_d = DONE;
                else              state_d = POP;
            end
            POP: begin
                hold_d  = HOLD_LOAD;
                state_d = (single_q || abort) ? IDLE : HOLD;
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (hold_q == '0) begin
`ifdef STACK_DRAIN_BLANK_EN
                    state_d = BLANK;
                    hold_d  = HOLD_LOAD;
`else
                    state_d = CHECK;
`endif
                end else begin
                    hold_d = hold_q - CW'(1);
                end
            end
`ifdef STACK_DRAIN_BLANK_EN
            BLANK: begin
                if (abort)               state_d = IDLE;
                else if (hold_q == '0)   state_d = CHECK;
                else                     hold_d  = hold_q - CW'(1);
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            single_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            single_q <= single_d;
            hold_q   <= hold_d;
        end
    end

    // LED latch, pop counter and underflow pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q       <= '0;
            led_valid_q <= 1'b0;
            pop_count_q <= '0;
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= (state_q == IDLE) && !start && single && s_empty;
            if (state_q == IDLE && start) begin
                pop_count_q <= '0;
            end
            if (state_q == POP) begin
                led_q       <= s_rd_data;
                led_valid_q <= 1'b1;
                if (pop_count_q != 8'hFF) pop_count_q <= pop_count_q + 8'd1;
            end
`ifdef STACK_DRAIN_BLANK_EN
            if (state_q == HOLD && hold_q == '0 && !abort) begin
                led_q       <= '0;
                led_valid_q <= 1'b0;
            end
`endif
        end
    end

    assign s_pop       = (state_q == POP);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign led         = led_q;
    assign led_valid   = led_valid_q;
    assign pop_count   = pop_count_q;
    assign underflow   = underflow_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stack_drain_reader.sv
// Bench for stack_drain_reader with HOLD_CYCLES=4 and a behavioural LIFO.
// Expected popped values go into exp_q when stimulus is issued; a monitor
// compares led after every s_pop.
module tb_stack_drain_reader;

    localparam int WIDTH = 8;
    localparam int HOLD  = 4;
`ifdef STACK_DRAIN_BLANK_EN
    localparam int SPACE = 2 * HOLD + 2;
`else
    localparam int SPACE = HOLD + 2;
`endif

    logic             clk;
    logic             reset_n;
    logic             start, single, abort;
    logic             s_empty;
    logic [WIDTH-1:0] s_rd_data;
    logic             s_pop;
    logic [WIDTH-1:0] led;
    logic             led_valid, busy, done, underflow;
    logic [7:0]       pop_count;
    logic [2:0]       dbg_state;

    stack_drain_reader #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .single(single),
        .abort(abort), .s_empty(s_empty), .s_rd_data(s_rd_data),
        .s_pop(s_pop), .led(led), .led_valid(led_valid), .busy(busy),
        .done(done), .underflow(underflow), .pop_count(pop_count),
        .dbg_state_o(dbg_state)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // behavioural stack: front of queue is top of stack
    logic [WIDTH-1:0] stk[$];
    logic             pop_now;
    initial begin
        s_empty   = 1'b1;
        s_rd_data = '0;
    end
    always @(posedge clk) begin
        pop_now = s_pop;
        #1;
        if (pop_now && stk.size() > 0) void'(stk.pop_front());
        s_empty   = (stk.size() == 0);
        s_rd_data = s_empty ? '0 : stk[0];
    end

    // scoreboard monitor
    logic [WIDTH-1:0] exp_q[$];
    int               pop_cyc[$];
    logic             chk_led = 1'b0;
    logic [WIDTH-1:0] exp_v;
    always @(negedge clk) begin
        if (chk_led && reset_n) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_pop: led=0x%0h with no expected value (cycle %0d)", led, cyc);
            end else begin
                exp_v = exp_q.pop_front();
                check("led_after_pop", {24'd0, led}, {24'd0, exp_v});
            end
        end
        chk_led = s_pop;
        if (s_pop) pop_cyc.push_back(cyc);
    end

    // driver helpers
    task automatic pulse_start(output int sc);
        @(negedge clk);
        start = 1'b1;
        sc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int dc, output bit ok);
        ok = 1'b0;
        dc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_pop(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_pop) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    int               sc, dc;
    bit               ok;
    logic [WIDTH-1:0] led_before;

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        single  = 1'b0;
        abort   = 1'b0;
        stk     = {8'hA5, 8'h3C, 8'h01};

        // reset with a loaded stack
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_s_pop", {31'd0, s_pop}, 0);
        check("rst_led", {24'd0, led}, 0);
        check("rst_led_valid", {31'd0, led_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_pop_count", {24'd0, pop_count}, 0);

        // full drain A5,3C,01
        pop_cyc.delete();
        exp_q = {8'hA5, 8'h3C, 8'h01};
        pulse_start(sc);
        wait_done(dc, ok);
        check("drain_done_seen", {31'd0, ok}, 1);
        check("drain_pop_n", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            check("drain_first_lat", pop_cyc[0] - sc, 1);
            check("drain_space1", pop_cyc[1] - pop_cyc[0], SPACE);
            check("drain_space2", pop_cyc[2] - pop_cyc[1], SPACE);
            check("drain_done_lat", dc - pop_cyc[2], SPACE);
        end
        check("drain_pop_count", {24'd0, pop_count}, 3);
`ifdef STACK_DRAIN_BLANK_EN
        check("drain_led_blank", {24'd0, led}, 0);
        check("drain_led_valid", {31'd0, led_valid}, 0);
`else
        check("drain_led_last", {24'd0, led}, 32'h01);
        check("drain_led_valid", {31'd0, led_valid}, 1);
`endif
        @(negedge clk);
        check("drain_busy_after", {31'd0, busy}, 0);

        // empty drain
        led_before = led;
        pulse_start(sc);
        wait_done(dc, ok);
        check("empty_done_seen", {31'd0, ok}, 1);
        check("empty_done_lat", dc - sc, 1);
        check("empty_pop_count", {24'd0, pop_count}, 0);
        check("empty_led_kept", {24'd0, led}, {24'd0, led_before});

        // single pop of 0x5A
        stk = {8'h5A};
        @(negedge clk);
        exp_q.push_back(8'h5A);
        single = 1'b1;
        @(negedge clk);
        single = 1'b0;
        check("single_s_pop", {31'd0, s_pop}, 1);
        @(negedge clk);
        check("single_busy", {31'd0, busy}, 0);
        check("single_led", {24'd0, led}, 32'h5A);
        check("single_pop_count", {24'd0, pop_count}, 1);

        // single on empty stack -> underflow pulse
        @(negedge clk);
        single = 1'b1;
        @(negedge clk);
        single = 1'b0;
        check("uflow_pulse", {31'd0, underflow}, 1);
        check("uflow_no_busy", {31'd0, busy}, 0);
        @(negedge clk);
        check("uflow_one_cycle", {31'd0, underflow}, 0);

        // start and single together -> drain wins
        stk = {8'h77, 8'h66};
        @(negedge clk);
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h66);
        start  = 1'b1;
        single = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        single = 1'b0;
        wait_done(dc, ok);
        check("both_done_seen", {31'd0, ok}, 1);
        check("both_pop_count", {24'd0, pop_count}, 2);

        // abort in the second HOLD cycle
        stk = {8'hA5, 8'h3C, 8'h01};
        @(negedge clk);
        exp_q.push_back(8'hA5);
        pulse_start(sc);
        wait_pop(ok);
        check("abort_pop_seen", {31'd0, ok}, 1);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 0);
        repeat (15) @(negedge clk);
        check("abort_led", {24'd0, led}, 32'hA5);
        check("abort_led_valid", {31'd0, led_valid}, 1);
        check("abort_pop_count", {24'd0, pop_count}, 1);

        // reset during POP
        pulse_start(sc);
        wait_pop(ok);
        check("rstmid_pop_seen", {31'd0, ok}, 1);
        #1 reset_n = 1'b0;
        #1;
        check("rstmid_s_pop", {31'd0, s_pop}, 0);
        check("rstmid_led", {24'd0, led}, 0);
        check("rstmid_led_valid", {31'd0, led_valid}, 0);
        check("rstmid_busy", {31'd0, busy}, 0);
        check("rstmid_pop_count", {24'd0, pop_count}, 0);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_idle_after", {29'd0, dbg_state}, 0);
        check("rstmid_no_pop_after", {31'd0, s_pop}, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
